bist_march_gen: RTL and testbench



---
 rtl/bist_pkg.sv | 55 +++++
 rtl/bist_addr_cnt.sv | 29 ++
 rtl/bist_march_gen.sv | 171 +++++++++++++++++
 tb/tb_bist_march_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// March C- generator shared definitions.
// Element table, FSM encoding and drain length.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef logic [2:0] elem_t;

    localparam elem_t E0 = 3'd0;
    localparam elem_t E1 = 3'd1;
    localparam elem_t E2 = 3'd2;
    localparam elem_t E3 = 3'd3;
    localparam elem_t E4 = 3'd4;
    localparam elem_t E5 = 3'd5;

    localparam int DRAIN_LEN = 2;

    // 1 = ascending address order
    function automatic logic elem_up(input elem_t e);
        return !(e == E3 || e == E4);
    endfunction

    // 1 = element has two ops (read then write) per address
    function automatic logic elem_two_ops(input elem_t e);
        return !(e == E0 || e == E5);
    endfunction

    // write enable of an op slot; slot 0 reads, slot 1 writes
    function automatic logic op_we(input elem_t e, input logic slot);
        logic r;
        unique case (1'b1)
            (e == E0): r = 1'b1;
            (e == E5): r = 1'b0;
            default:   r = slot;
        endcase
        return r;
    endfunction

    // background of an op slot; 1 = all-ones
    function automatic logic op_val(input elem_t e, input logic slot);
        logic r;
        unique case (1'b1)
            (e == E1 || e == E3): r = slot;
            (e == E2 || e == E4): r = !slot;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bist_addr_cnt.sv
// Loadable up/down address counter.
// Terminal count flags the last address in the current direction.
module bist_addr_cnt #(
    parameter int pADDR_WIDTH = 4
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   load,
    input  logic [pADDR_WIDTH-1:0] load_val,
    input  logic                   en,
    input  logic                   down,
    output logic [pADDR_WIDTH-1:0] cnt,
    output logic                   tc
);

    // load has priority over stepping
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= down ? cnt - 1'b1 : cnt + 1'b1;
        end
    end

    assign tc = down ? (cnt == '0) : (cnt == '1);

endmodule

// File: rtl/bist_march_gen.sv
// March C- sequencer driving the memory under test.
// Captures sticky fail and first failing address from the comparator.
module bist_march_gen
    import bist_pkg::*;
#(
    parameter int pADDR_WIDTH = 4,
    parameter int pDATA_WIDTH = 2
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   bist_start,
    input  logic                   pass_or_fail,
    output logic                   bist_cs,
    output logic                   bist_we,
    output logic [pADDR_WIDTH-1:0] bist_addr,
    output logic [pDATA_WIDTH-1:0] bist_pat,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_fail,
    output logic [pADDR_WIDTH-1:0] bist_fail_addr
);

    state_t state_q, state_d;
    elem_t  elem_q, elem_d;
    logic   slot_q, slot_d;
    logic [1:0] drain_q, drain_d;

    logic                   cnt_load;
    logic [pADDR_WIDTH-1:0] cnt_load_val;
    logic                   cnt_en;
    logic [pADDR_WIDTH-1:0] cnt;
    logic                   cnt_tc;
    logic                   go;

    logic                   cs_d, we_d, busy_d, done_d;
    logic [pADDR_WIDTH-1:0] addr_d;
    logic [pDATA_WIDTH-1:0] pat_d;

    logic [1:0]             rd_q;
    logic [pADDR_WIDTH-1:0] ra0_q, ra1_q;

    bist_addr_cnt #(.pADDR_WIDTH(pADDR_WIDTH)) u_cnt (
        .bist_clk   (bist_clk),
        .bist_rst_n (bist_rst_n),
        .load       (cnt_load),
        .load_val   (cnt_load_val),
        .en         (cnt_en),
        .down       (!elem_up(elem_q)),
        .cnt        (cnt),
        .tc         (cnt_tc)
    );

    assign go = bist_start && (state_q == ST_IDLE || state_q == ST_DONE);

    // next state, op sequencing and next registered outputs
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        slot_d       = slot_q;
        drain_d      = drain_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = bist_addr;
        pat_d        = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d = (state_q == ST_DONE);
                if (go) begin
                    state_d  = ST_RUN;
                    elem_d   = E0;
                    slot_d   = 1'b0;
                    cnt_load = 1'b1;
                    done_d   = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                we_d   = op_we(elem_q, slot_q);
                addr_d = cnt;
                pat_d  = {pDATA_WIDTH{op_val(elem_q, slot_q)}};
                if (elem_two_ops(elem_q) && !slot_q) begin
                    slot_d = 1'b1;
                end else begin
                    slot_d = 1'b0;
                    if (!cnt_tc) begin
                        cnt_en = 1'b1;
                    end else if (elem_q == E5) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        elem_d       = elem_t'(elem_q + 3'd1);
                        cnt_load     = 1'b1;
                        cnt_load_val = elem_up(elem_d) ? '0 : '1;
                    end
                end
            end
            ST_DRAIN: begin
                busy_d  = 1'b1;
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_LEN - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // FSM, sequencing and output registers
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            state_q   <= ST_IDLE;
            elem_q    <= E0;
            slot_q    <= 1'b0;
            drain_q   <= '0;
            bist_cs   <= 1'b0;
            bist_we   <= 1'b0;
            bist_addr <= '0;
            bist_pat  <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            slot_q    <= slot_d;
            drain_q   <= drain_d;
            bist_cs   <= cs_d;
            bist_we   <= we_d;
            bist_addr <= addr_d;
            bist_pat  <= pat_d;
            bist_busy <= busy_d;
            bist_done <= done_d;
        end
    end

    // read strobe/address delayed to line up with the comparator result
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            rd_q  <= '0;
            ra0_q <= '0;
            ra1_q <= '0;
        end else begin
            rd_q  <= {rd_q[0], cs_d && !we_d};
            ra0_q <= addr_d;
            ra1_q <= ra0_q;
        end
    end

    // sticky fail with first-fail address, cleared on start
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
        end else if (go) begin
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
        end else if (rd_q[1] && !pass_or_fail) begin
            bist_fail <= 1'b1;
            if (!bist_fail) begin
                bist_fail_addr <= ra1_q;
            end
        end
    end

endmodule

// File: tb/tb_bist_march_gen.sv
// Directed bench for the March C- generator.
// Memory and comparator models with injectable faults; op scoreboard.
module tb_bist_march_gen;

    logic       bist_clk;
    logic       bist_rst_n;
    logic       bist_start;
    logic       pass_or_fail;
    logic       bist_cs;
    logic       bist_we;
    logic [1:0] bist_addr;
    logic [1:0] bist_pat;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_fail;
    logic [1:0] bist_fail_addr;

    bist_march_gen #(.pADDR_WIDTH(2), .pDATA_WIDTH(2)) dut (
        .bist_clk       (bist_clk),
        .bist_rst_n     (bist_rst_n),
        .bist_start     (bist_start),
        .pass_or_fail   (pass_or_fail),
        .bist_cs        (bist_cs),
        .bist_we        (bist_we),
        .bist_addr      (bist_addr),
        .bist_pat       (bist_pat),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr)
    );

    initial bist_clk = 1'b0;
    always #5 bist_clk = ~bist_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ops_seen = 0;
    int fault = 0;

    logic [4:0] q[$];
    logic [4:0] op_log[$];

    // 0: none, 1: addr 2 bit 0 stuck at 1, 2: addr 1 cells cannot rise
    logic [1:0] mem[4];
    logic [1:0] rdata;

    assign rdata = (fault == 1 && bist_addr == 2'd2) ?
                   (mem[bist_addr] | 2'b01) : mem[bist_addr];

    always @(posedge bist_clk) begin
        if (bist_cs && bist_we) begin
            if (fault == 2 && bist_addr == 2'd1)
                mem[1] <= mem[1] & bist_pat;
            else
                mem[bist_addr] <= bist_pat;
        end
    end

    always @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n)
            pass_or_fail <= 1'b1;
        else
            pass_or_fail <= !(bist_cs && !bist_we) || (rdata == bist_pat);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // March C- reference table
    int nops[6] = '{1, 2, 2, 2, 2, 1};
    bit upd[6]  = '{1, 1, 1, 0, 0, 1};
    bit wr0[6]  = '{1, 0, 0, 0, 0, 0};
    bit v0[6]   = '{0, 0, 1, 0, 1, 0};
    bit v1[6]   = '{0, 1, 0, 1, 0, 0};

    task automatic push_expected();
        logic [1:0] a2;
        bit we, v;
        for (int e = 0; e < 6; e++)
            for (int a = 0; a < 4; a++)
                for (int s = 0; s < nops[e]; s++) begin
                    a2 = upd[e] ? 2'(a) : 2'(3 - a);
                    we = (s == 0) ? wr0[e] : 1'b1;
                    v  = (s == 0) ? v0[e] : v1[e];
                    q.push_back({we, a2, {2{v}}});
                end
    endtask

    // scoreboard pop on each issued op; idle bus must be quiet
    always @(negedge bist_clk) begin
        logic [4:0] got;
        logic [4:0] exp;
        if (bist_rst_n) begin
            got = {bist_we, bist_addr, bist_pat};
            if (bist_cs) begin
                op_log.push_back(got);
                ops_seen++;
                chk("op_q_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    chk("op", 32'(got), 32'(exp));
                end
            end else begin
                chk("idle_quiet", 32'({bist_we, bist_pat}), 0);
            end
        end
    end

    task automatic run_march(input string nm, input bit exp_fail,
                             input logic [1:0] exp_fa, input bit pulses);
        int done_at;
        int busy_n;
        done_at  = 0;
        busy_n   = 0;
        ops_seen = 0;
        op_log.delete();
        push_expected();
        @(negedge bist_clk);
        bist_start = 1'b1;
        @(posedge bist_clk);
        #1;
        bist_start = 1'b0;
        chk({nm, "_start_edge"}, 32'({bist_done, bist_fail, bist_busy}), 0);
        for (int i = 1; i <= 60; i++) begin
            bist_start = pulses && (i % 7 == 0) && (i < 40);
            @(posedge bist_clk);
            #1;
            if (bist_busy) busy_n++;
            if (bist_done) begin
                done_at = i;
                break;
            end
        end
        bist_start = 1'b0;
        chk({nm, "_done_at"}, 32'(done_at), 42);
        chk({nm, "_busy_cycles"}, 32'(busy_n), 41);
        chk({nm, "_op_count"}, 32'(ops_seen), 40);
        chk({nm, "_q_empty"}, 32'(q.size()), 0);
        chk({nm, "_fail"}, 32'(bist_fail), 32'(exp_fail));
        chk({nm, "_fail_addr"}, 32'(bist_fail_addr), 32'(exp_fa));
    endtask

    initial begin
        bist_rst_n = 1'b0;
        bist_start = 1'b0;
        fault      = 0;
        #12;
        chk("reset_outputs",
            32'({bist_cs, bist_we, bist_addr, bist_pat, bist_busy,
                 bist_done, bist_fail, bist_fail_addr}), 0);
        @(negedge bist_clk);
        bist_rst_n = 1'b1;
        repeat (2) @(posedge bist_clk);

        run_march("good", 1'b0, 2'd0, 1'b0);
        chk("log_op0", 32'(op_log[0]), 32'(5'b1_00_00));
        chk("log_op1", 32'(op_log[1]), 32'(5'b1_01_00));
        chk("log_op2", 32'(op_log[2]), 32'(5'b1_10_00));
        chk("log_op3", 32'(op_log[3]), 32'(5'b1_11_00));
        chk("log_e3_r0", 32'(op_log[20]), 32'(5'b0_11_00));
        chk("log_e3_w1", 32'(op_log[21]), 32'(5'b1_11_11));
        chk("log_last", 32'(op_log[39]), 32'(5'b0_11_00));
        repeat (3) @(posedge bist_clk);
        #1;
        chk("done_hold", 32'({bist_done, bist_busy, bist_cs}), 32'(3'b100));

        fault = 1;
        run_march("stuck", 1'b1, 2'd2, 1'b0);

        push_expected();
        @(negedge bist_clk);
        bist_start = 1'b1;
        @(posedge bist_clk);
        #1;
        bist_start = 1'b0;
        repeat (17) @(posedge bist_clk);
        #1;
        chk("abort_pre_fail", 32'({bist_fail, bist_busy, bist_cs}), 32'(3'b111));
        #1;
        bist_rst_n = 1'b0;
        #1;
        chk("abort_outputs",
            32'({bist_cs, bist_busy, bist_done, bist_fail, bist_fail_addr}), 0);
        q.delete();
        @(negedge bist_clk);
        bist_rst_n = 1'b1;
        repeat (5) @(posedge bist_clk);
        #1;
        chk("abort_idle", 32'({bist_cs, bist_busy, bist_done, bist_fail}), 0);

        fault = 2;
        run_march("trans", 1'b1, 2'd1, 1'b0);

        fault = 0;
        run_march("restart", 1'b0, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
